// File: rtl/msk_aes_pkg.sv
// Shared helpers for the masked AES datapath: GF(2^8) reduction constant,
// xtime, and the bit-interleaved share index mapping.
package msk_aes_pkg;

    // Low byte of the AES field polynomial x^8 + x^4 + x^3 + x + 1
    localparam logic [7:0] gf_red = 8'h1B;

    // Multiply by x in GF(2^8)
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? gf_red : 8'h00);
    endfunction

    // Vector position of bit idx_bit of share idx_share in a d-share bus
    function automatic int unsigned shidx(input int unsigned idx_bit,
                                          input int unsigned idx_share,
                                          input int unsigned nshares);
        return idx_bit * nshares + idx_share;
    endfunction

endpackage

// File: rtl/mc_inv_prod.sv
// Single-share, single-byte producer of the InvMixColumns multiples
// 09, 0b, 0d and 0e, built from a three-deep xtime chain.
module mc_inv_prod
    import msk_aes_pkg::*;
(
    input  logic [7:0] b,
    output logic [7:0] m09,
    output logic [7:0] m0b,
    output logic [7:0] m0d,
    output logic [7:0] m0e
);

    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;

    // xtime chain and recombination into the four coefficients
    always_comb begin
        x2  = xtime(b);
        x4  = xtime(x2);
        x8  = xtime(x4);
        m09 = x8 ^ b;
        m0b = x8 ^ x2 ^ b;
        m0d = x8 ^ x4 ^ b;
        m0e = x8 ^ x4 ^ x2;
    end

endmodule

// File: rtl/msk_aes_mc_inv.sv
// Masked AES InvMixColumns on one column. The transform is linear, so each
// share is processed on its own; bits of different shares never meet in
// any XOR. Outputs are registered with one cycle of latency.
module msk_aes_mc_inv
    import msk_aes_pkg::*;
#(
    parameter int unsigned d = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    input  logic [8*d-1:0] b0,
    input  logic [8*d-1:0] b1,
    input  logic [8*d-1:0] b2,
    input  logic [8*d-1:0] b3,
    output logic           out_valid,
    output logic [8*d-1:0] a0,
    output logic [8*d-1:0] a1,
    output logic [8*d-1:0] a2,
    output logic [8*d-1:0] a3
);

    logic [3:0][8*d-1:0] bin;
    logic [3:0][8*d-1:0] anxt;

    assign bin = {b3, b2, b1, b0};

    for (genvar s = 0; s < d; s++) begin : g_share
        logic [3:0][7:0] bi;
        logic [3:0][7:0] p9;
        logic [3:0][7:0] pb;
        logic [3:0][7:0] pd;
        logic [3:0][7:0] pe;
        logic [3:0][7:0] ao;

        for (genvar r = 0; r < 4; r++) begin : g_row
            for (genvar j = 0; j < 8; j++) begin : g_in
                assign bi[r][j] = bin[r][shidx(j, s, d)];
            end

            mc_inv_prod u_prod (
                .b   (bi[r]),
                .m09 (p9[r]),
                .m0b (pb[r]),
                .m0d (pd[r]),
                .m0e (pe[r])
            );
        end

        assign ao[0] = pe[0] ^ pb[1] ^ pd[2] ^ p9[3];
        assign ao[1] = p9[0] ^ pe[1] ^ pb[2] ^ pd[3];
        assign ao[2] = pd[0] ^ p9[1] ^ pe[2] ^ pb[3];
        assign ao[3] = pb[0] ^ pd[1] ^ p9[2] ^ pe[3];

        for (genvar r = 0; r < 4; r++) begin : g_out
            for (genvar j = 0; j < 8; j++) begin : g_bit
                assign anxt[r][shidx(j, s, d)] = ao[r][j];
            end
        end
    end

    // Output register: reset clears everything, data loads only on in_valid
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            a0        <= '0;
            a1        <= '0;
            a2        <= '0;
            a3        <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                a0 <= anxt[0];
                a1 <= anxt[1];
                a2 <= anxt[2];
                a3 <= anxt[3];
            end
        end
    end

endmodule

// File: tb/tb_msk_aes_mc_inv.sv
// Directed bench for msk_aes_mc_inv with d = 1, 2 and 3 instances side by side.
module tb_msk_aes_mc_inv;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid;

    logic [7:0]  i1 [4];
    logic [7:0]  o1 [4];
    logic [15:0] i2 [4];
    logic [15:0] o2 [4];
    logic [23:0] i3 [4];
    logic [23:0] o3 [4];
    logic        v1, v2, v3;

    int cmp = 0;
    int bad = 0;

    always #5 clk = ~clk;

    msk_aes_mc_inv #(.d(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .b0(i1[0]), .b1(i1[1]), .b2(i1[2]), .b3(i1[3]),
        .out_valid(v1), .a0(o1[0]), .a1(o1[1]), .a2(o1[2]), .a3(o1[3])
    );

    msk_aes_mc_inv #(.d(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .b0(i2[0]), .b1(i2[1]), .b2(i2[2]), .b3(i2[3]),
        .out_valid(v2), .a0(o2[0]), .a1(o2[1]), .a2(o2[2]), .a3(o2[3])
    );

    msk_aes_mc_inv #(.d(3)) u_d3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .b0(i3[0]), .b1(i3[1]), .b2(i3[2]), .b3(i3[3]),
        .out_valid(v3), .a0(o3[0]), .a1(o3[1]), .a2(o3[2]), .a3(o3[3])
    );

    // Reference GF(2^8) multiply, shift-and-add
    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p = 8'h00;
        logic [7:0] a = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1B) : (a << 1);
        end
        return p;
    endfunction

    // Column word is {row0, row1, row2, row3}
    function automatic logic [31:0] invmc(input logic [31:0] c);
        logic [7:0] b [4];
        logic [7:0] r [4];
        for (int i = 0; i < 4; i++) b[i] = c[31-8*i -: 8];
        r[0] = gmul(8'h0e, b[0]) ^ gmul(8'h0b, b[1]) ^ gmul(8'h0d, b[2]) ^ gmul(8'h09, b[3]);
        r[1] = gmul(8'h09, b[0]) ^ gmul(8'h0e, b[1]) ^ gmul(8'h0b, b[2]) ^ gmul(8'h0d, b[3]);
        r[2] = gmul(8'h0d, b[0]) ^ gmul(8'h09, b[1]) ^ gmul(8'h0e, b[2]) ^ gmul(8'h0b, b[3]);
        r[3] = gmul(8'h0b, b[0]) ^ gmul(8'h0d, b[1]) ^ gmul(8'h09, b[2]) ^ gmul(8'h0e, b[3]);
        return {r[0], r[1], r[2], r[3]};
    endfunction

    function automatic logic [7:0] getb(input logic [23:0] v, input int dd, input int s);
        logic [7:0] r;
        for (int j = 0; j < 8; j++) r[j] = v[j*dd+s];
        return r;
    endfunction

    function automatic logic [23:0] putb(input logic [23:0] v, input logic [7:0] b,
                                         input int dd, input int s);
        logic [23:0] r = v;
        for (int j = 0; j < 8; j++) r[j*dd+s] = b[j];
        return r;
    endfunction

    // Output share s of the d=2 instance as a column word
    function automatic logic [31:0] sh2(input int s);
        logic [31:0] c;
        for (int i = 0; i < 4; i++) c[31-8*i -: 8] = getb({8'h00, o2[i]}, 2, s);
        return c;
    endfunction

    function automatic logic [31:0] rec1();
        return {o1[0], o1[1], o1[2], o1[3]};
    endfunction

    function automatic logic [31:0] rec2();
        return sh2(0) ^ sh2(1);
    endfunction

    function automatic logic [31:0] rec3();
        logic [31:0] c = '0;
        for (int s = 0; s < 3; s++)
            for (int i = 0; i < 4; i++)
                c[31-8*i -: 8] = c[31-8*i -: 8] ^ getb(o3[i], 3, s);
        return c;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        cmp++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive unmasked column c: d=2 share0 = m, d=3 shares = m, m3, c^m^m3
    task automatic drive_col(input logic [31:0] c, input logic [31:0] m);
        logic [31:0] m3;
        logic [23:0] t2, t3;
        m3 = $urandom;
        for (int i = 0; i < 4; i++) begin
            i1[i] = c[31-8*i -: 8];
            t2 = putb(24'h0, m[31-8*i -: 8], 2, 0);
            t2 = putb(t2, c[31-8*i -: 8] ^ m[31-8*i -: 8], 2, 1);
            i2[i] = t2[15:0];
            t3 = putb(24'h0, m[31-8*i -: 8], 3, 0);
            t3 = putb(t3, m3[31-8*i -: 8], 3, 1);
            t3 = putb(t3, c[31-8*i -: 8] ^ m[31-8*i -: 8] ^ m3[31-8*i -: 8], 3, 2);
            i3[i] = t3;
        end
    endtask

    typedef struct {
        logic [31:0] col;
        logic [31:0] exp;
    } vec_t;

    vec_t tv [6];
    logic [31:0] m;
    logic [31:0] hold;

    initial begin
        tv[0] = '{col: 32'h8e4da1bc, exp: 32'hdb135345};
        tv[1] = '{col: 32'hd5d5d7d6, exp: 32'hd4d4d4d5};
        tv[2] = '{col: 32'h9fdc589d, exp: 32'hf20a225c};
        tv[3] = '{col: 32'h01010101, exp: 32'h01010101};
        tv[4] = '{col: 32'hc6c6c6c6, exp: 32'hc6c6c6c6};
        tv[5] = '{col: 32'h4d7ebdf8, exp: 32'h2d26314c};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        drive_col(32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", {29'd0, v1, v2, v3}, 32'h0);
        chk("reset_d1", rec1(), 32'h0);
        chk("reset_d2_s0", sh2(0), 32'h0);
        chk("reset_d2_s1", sh2(1), 32'h0);
        chk("reset_d3", rec3(), 32'h0);
        rst_n = 1'b1;

        // Table: one column per row, idle between rows
        for (int i = 0; i < 6; i++) begin
            m = (i == 0) ? 32'h0 : $urandom;
            drive_col(tv[i].col, m);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            chk("tbl_valid", {29'd0, v1, v2, v3}, 32'h7);
            chk("tbl_d1", rec1(), tv[i].exp);
            chk("tbl_d2", rec2(), tv[i].exp);
            chk("tbl_d3", rec3(), tv[i].exp);
            chk("tbl_d2_share0", sh2(0), invmc(m));
            chk("tbl_d2_share1", sh2(1), invmc(tv[i].col ^ m));
            @(posedge clk);
            #1;
            chk("tbl_idle_valid", {31'd0, v2}, 32'h0);
            chk("tbl_idle_hold", rec2(), tv[i].exp);
        end

        // Streaming: four back-to-back columns then one idle cycle
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: hold = 32'h4d7ebdf8;
                1: hold = 32'h9fdc589d;
                2: hold = 32'h8e4da1bc;
                default: hold = 32'hd5d5d7d6;
            endcase
            drive_col(hold, $urandom);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            chk("stream_valid", {31'd0, v2}, 32'h1);
            case (k)
                0: chk("stream_data", rec2(), 32'h2d26314c);
                1: chk("stream_data", rec2(), 32'hf20a225c);
                2: chk("stream_data", rec2(), 32'hdb135345);
                default: chk("stream_data", rec2(), 32'hd4d4d4d5);
            endcase
        end
        in_valid = 1'b0;
        drive_col(32'h12345678, $urandom);
        @(posedge clk);
        #1;
        chk("stream_idle_valid", {31'd0, v2}, 32'h0);
        chk("stream_idle_hold", rec2(), 32'hd4d4d4d5);

        // Reset wins over a simultaneous valid column
        rst_n = 1'b0;
        drive_col(32'h9fdc589d, $urandom);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_prio_valid", {29'd0, v1, v2, v3}, 32'h0);
        chk("rst_prio_d1", rec1(), 32'h0);
        chk("rst_prio_d2_s0", sh2(0), 32'h0);
        chk("rst_prio_d2_s1", sh2(1), 32'h0);
        chk("rst_prio_d3", rec3(), 32'h0);
        rst_n = 1'b1;
        drive_col(32'h8e4da1bc, $urandom);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("post_rst_valid", {29'd0, v1, v2, v3}, 32'h7);
        chk("post_rst_d2", rec2(), 32'hdb135345);
        chk("post_rst_d3", rec3(), 32'hdb135345);

        // Single-byte sweep on row 0, d=2
        for (int b = 0; b < 256; b++) begin
            hold = {b[7:0], 24'h0};
            drive_col(hold, {8'($urandom), 24'h0});
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            chk("sweep", rec2(), {gmul(8'h0e, b[7:0]), gmul(8'h09, b[7:0]),
                                  gmul(8'h0d, b[7:0]), gmul(8'h0b, b[7:0])});
        end
        in_valid = 1'b0;
        @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end

endmodule
